// File: rtl/hazard_control_unit_if.sv
// Decode-side control bundle between the ID stage and the hazard/branch unit.
// Latency: none, this is wiring only.
// Backpressure: none; the stall outputs carried here are the pipeline's backpressure.
interface hazard_control_unit_if;
  // ID instruction description
  logic       id_valid;
  logic [4:0] IF_ID_rs1;
  logic [4:0] IF_ID_rs2;
  logic [4:0] IF_ID_rd;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       reg_write;
  logic       mem_read;
  logic       id_branch;
  logic       id_bne;
  logic       id_jump;
  logic       br_eq;
  // pipeline control back to fetch/decode
  logic       pc_write;
  logic       IF_ID_write;
  logic       IF_ID_flush;
  logic       pc_sel;
  logic       ctrl_sel;
  logic [1:0] forward_comp1;
  logic [1:0] forward_comp2;

  modport master (
    output id_valid, IF_ID_rs1, IF_ID_rs2, IF_ID_rd, id_use_rs1, id_use_rs2,
           reg_write, mem_read, id_branch, id_bne, id_jump, br_eq,
    input  pc_write, IF_ID_write, IF_ID_flush, pc_sel, ctrl_sel,
           forward_comp1, forward_comp2
  );

  modport slave (
    input  id_valid, IF_ID_rs1, IF_ID_rs2, IF_ID_rd, id_use_rs1, id_use_rs2,
           reg_write, mem_read, id_branch, id_bne, id_jump, br_eq,
    output pc_write, IF_ID_write, IF_ID_flush, pc_sel, ctrl_sel,
           forward_comp1, forward_comp2
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard, forwarding and branch-redirect control for the 5-stage core, beside decode.
// Latency: control outputs are combinational (0 cycles); shadow state and counters registered.
// Backpressure: stalls fetch/decode on load-use and WB-only dependencies, flushes IF/ID on redirect.
module hazard_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  hazard_control_unit_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // One shadow slot per downstream stage: destination register and its write class.
  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } sh_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sh_t        sh_ex;
  sh_t        sh_mem;
  sh_t        sh_wb;
  logic [1:0] fwd1;
  logic [1:0] fwd2;
  logic       stall1;
  logic       stall2;
  logic       stall;
  logic       taken;
  logic       issue;

  // x0 is hardwired to zero, so it never creates a dependency.
  function automatic logic hit(input sh_t s, input logic use_rs, input logic [4:0] rs);
    return use_rs && (rs != 5'd0) && s.reg_write && (s.rd == rs);
  endfunction

  // Per-operand resolution, youngest producer first; the regfile has no write-through,
  // so a producer sitting only in WB must be waited out for one cycle.
  always_comb begin
    fwd1   = FWD_RF;
    stall1 = 1'b0;
    fwd2   = FWD_RF;
    stall2 = 1'b0;
    if (hit(sh_ex, bus.id_use_rs1, bus.IF_ID_rs1)) begin
      if (sh_ex.mem_read) stall1 = 1'b1;
      else                fwd1   = FWD_EX;
    end else if (hit(sh_mem, bus.id_use_rs1, bus.IF_ID_rs1)) begin
      fwd1 = FWD_MEM;
    end else if (hit(sh_wb, bus.id_use_rs1, bus.IF_ID_rs1)) begin
      stall1 = 1'b1;
    end
    if (hit(sh_ex, bus.id_use_rs2, bus.IF_ID_rs2)) begin
      if (sh_ex.mem_read) stall2 = 1'b1;
      else                fwd2   = FWD_EX;
    end else if (hit(sh_mem, bus.id_use_rs2, bus.IF_ID_rs2)) begin
      fwd2 = FWD_MEM;
    end else if (hit(sh_wb, bus.id_use_rs2, bus.IF_ID_rs2)) begin
      stall2 = 1'b1;
    end
  end

  // A stalled branch is not resolved now; it is re-evaluated once its operands are ready.
  always_comb begin
    stall = bus.id_valid & (stall1 | stall2);
    issue = bus.id_valid & ~stall;
    taken = issue & (bus.id_jump | (bus.id_branch & (bus.br_eq ^ bus.id_bne)));
  end

  // Drive pipeline control; everything is held quiet while reset is asserted.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.IF_ID_write   = 1'b0;
    bus.IF_ID_flush   = 1'b0;
    bus.pc_sel        = 1'b0;
    bus.ctrl_sel      = 1'b0;
    bus.forward_comp1 = FWD_RF;
    bus.forward_comp2 = FWD_RF;
    if (reset_n) begin
      bus.pc_write      = ~stall;
      bus.IF_ID_write   = ~stall;
      bus.ctrl_sel      = issue;
      bus.pc_sel        = taken;
      bus.IF_ID_flush   = taken;
      bus.forward_comp1 = fwd1;
      bus.forward_comp2 = fwd2;
    end
  end

  // Advance the shadow pipeline (bubble on stall or empty ID) and bump saturating counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sh_ex     <= '0;
      sh_mem    <= '0;
      sh_wb     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      sh_wb  <= sh_mem;
      sh_mem <= sh_ex;
      sh_ex  <= issue ? sh_t'{rd: bus.IF_ID_rd, reg_write: bus.reg_write, mem_read: bus.mem_read}
                      : sh_t'('0);
      if (stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
      if (taken && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomised and directed bench for hazard_control_unit with a queue-based scoreboard.
// Latency: expectations are pushed when inputs are applied and popped half a cycle later.
// Backpressure: directed instructions are re-presented while the reference model says stall.
module tb_hazard_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [2:0]  s_stall_cnt;
  logic [2:0]  s_flush_cnt;

  hazard_control_unit_if bus ();
  hazard_control_unit_if bus_s ();

  hazard_control_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  // Narrow-counter copy sees identical stimulus so saturation is reached quickly.
  hazard_control_unit #(.CNT_W(3)) dut_s (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus_s),
    .stall_cnt (s_stall_cnt),
    .flush_cnt (s_flush_cnt)
  );

  assign bus_s.id_valid   = bus.id_valid;
  assign bus_s.IF_ID_rs1  = bus.IF_ID_rs1;
  assign bus_s.IF_ID_rs2  = bus.IF_ID_rs2;
  assign bus_s.IF_ID_rd   = bus.IF_ID_rd;
  assign bus_s.id_use_rs1 = bus.id_use_rs1;
  assign bus_s.id_use_rs2 = bus.id_use_rs2;
  assign bus_s.reg_write  = bus.reg_write;
  assign bus_s.mem_read   = bus.mem_read;
  assign bus_s.id_branch  = bus.id_branch;
  assign bus_s.id_bne     = bus.id_bne;
  assign bus_s.id_jump    = bus.id_jump;
  assign bus_s.br_eq      = bus.br_eq;

  typedef struct {
    bit   stall;
    bit   pcw;
    bit   ifw;
    bit   flush;
    bit   psel;
    bit   ctrl;
    int   f1;
    int   f2;
    int   scnt;
    int   fcnt;
    int   sscnt;
    int   sfcnt;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: the last three ID slots that actually issued (age 1 = just issued).
  int   h_rd [1:3];
  bit   h_wr [1:3];
  bit   h_ld [1:3];
  int   n_stall = 0;
  int   n_flush = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Youngest in-flight writer of rs decides: age 1 forwards from EX unless it is a load,
  // age 2 forwards from MEM, age 3 is still being written back and must be waited for.
  task automatic resolve(input bit u, input int rs, output int fw, output bit st);
    bit found;
    fw = 0;
    st = 1'b0;
    found = 1'b0;
    if (u && rs != 0) begin
      for (int d = 1; d <= 3; d++) begin
        if (!found && h_wr[d] && h_rd[d] == rs) begin
          found = 1'b1;
          if (d == 1) begin
            if (h_ld[d]) st = 1'b1;
            else         fw = 1;
          end else if (d == 2) begin
            fw = 2;
          end else begin
            st = 1'b1;
          end
        end
      end
    end
  endtask

  // Apply one cycle of ID inputs, push the expected response, then advance the model.
  task automatic drive(input bit rn, input bit valid, input int rs1, input int rs2, input int rd,
                       input bit u1, input bit u2, input bit rw, input bit mr,
                       input bit br, input bit bne, input bit jmp, input bit eq,
                       output bit stalled);
    exp_t e;
    int   fw1, fw2;
    bit   st1, st2, st, tk, iss;
    logic [31:0] v1, v2, vd;
    v1 = rs1; v2 = rs2; vd = rd;
    reset_n        = rn;
    bus.id_valid   = valid;
    bus.IF_ID_rs1  = v1[4:0];
    bus.IF_ID_rs2  = v2[4:0];
    bus.IF_ID_rd   = vd[4:0];
    bus.id_use_rs1 = u1;
    bus.id_use_rs2 = u2;
    bus.reg_write  = rw;
    bus.mem_read   = mr;
    bus.id_branch  = br;
    bus.id_bne     = bne;
    bus.id_jump    = jmp;
    bus.br_eq      = eq;
    resolve(u1, rs1, fw1, st1);
    resolve(u2, rs2, fw2, st2);
    st  = valid && (st1 || st2);
    iss = valid && !st;
    tk  = iss && (jmp || (br && (eq != bne)));
    e.scnt  = imin(n_stall, 65535);
    e.fcnt  = imin(n_flush, 65535);
    e.sscnt = imin(n_stall, 7);
    e.sfcnt = imin(n_flush, 7);
    if (!rn) begin
      e.stall = 1'b0; e.pcw = 1'b0; e.ifw = 1'b0; e.flush = 1'b0;
      e.psel = 1'b0; e.ctrl = 1'b0; e.f1 = 0; e.f2 = 0;
      for (int d = 1; d <= 3; d++) begin h_rd[d] = 0; h_wr[d] = 1'b0; h_ld[d] = 1'b0; end
      n_stall = 0;
      n_flush = 0;
      stalled = 1'b0;
    end else begin
      e.stall = st; e.pcw = !st; e.ifw = !st; e.flush = tk;
      e.psel = tk; e.ctrl = iss; e.f1 = fw1; e.f2 = fw2;
      for (int d = 3; d >= 2; d--) begin
        h_rd[d] = h_rd[d-1]; h_wr[d] = h_wr[d-1]; h_ld[d] = h_ld[d-1];
      end
      h_rd[1] = iss ? rd : 0;
      h_wr[1] = iss && rw;
      h_ld[1] = iss && mr;
      if (st) n_stall++;
      if (tk) n_flush++;
      stalled = st;
    end
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it in ID while it is stalled, as the real IF/ID would.
  task automatic instr(input int rs1, input int rs2, input int rd, input bit u1, input bit u2,
                       input bit rw, input bit mr, input bit br, input bit bne,
                       input bit jmp, input bit eq);
    bit st;
    int n;
    n = 0;
    do begin
      drive(1'b1, 1'b1, rs1, rs2, rd, u1, u2, rw, mr, br, bne, jmp, eq, st);
      n++;
    end while (st && n < 4);
  endtask

  task automatic alu(input int rd, input int rs1, input int rs2);
    instr(rs1, rs2, rd, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lw(input int rd, input int rs1);
    instr(rs1, 0, rd, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic branch(input int rs1, input int rs2, input bit bne, input bit eq);
    instr(rs1, rs2, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, bne, 1'b0, eq);
  endtask

  task automatic jal(input int rd, input bit eq);
    instr(0, 0, rd, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, eq);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational, so each pushed expectation is checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("pc_write",    {31'd0, bus.pc_write},    {31'd0, e.pcw});
        chk("IF_ID_write", {31'd0, bus.IF_ID_write}, {31'd0, e.ifw});
        chk("IF_ID_flush", {31'd0, bus.IF_ID_flush}, {31'd0, e.flush});
        chk("pc_sel",      {31'd0, bus.pc_sel},      {31'd0, e.psel});
        chk("ctrl_sel",    {31'd0, bus.ctrl_sel},    {31'd0, e.ctrl});
        if (!e.stall) begin
          chk("forward_comp1", {30'd0, bus.forward_comp1}, e.f1);
          chk("forward_comp2", {30'd0, bus.forward_comp2}, e.f2);
        end
        chk("stall_cnt",   {16'd0, stall_cnt},   e.scnt);
        chk("flush_cnt",   {16'd0, flush_cnt},   e.fcnt);
        chk("stall_cnt_w3", {29'd0, s_stall_cnt}, e.sscnt);
        chk("flush_cnt_w3", {29'd0, s_flush_cnt}, e.sfcnt);
      end
    end
  end

  initial begin
    bit st;
    reset_n        = 1'b0;
    bus.id_valid   = 1'b1;
    bus.IF_ID_rs1  = 5'd1;
    bus.IF_ID_rs2  = 5'd2;
    bus.IF_ID_rd   = 5'd3;
    bus.id_use_rs1 = 1'b1;
    bus.id_use_rs2 = 1'b1;
    bus.reg_write  = 1'b1;
    bus.mem_read   = 1'b0;
    bus.id_branch  = 1'b0;
    bus.id_bne     = 1'b0;
    bus.id_jump    = 1'b0;
    bus.br_eq      = 1'b0;
    @(posedge clk);
    #1;

    // Two reset cycles with a live instruction in ID.
    drive(1'b0, 1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, st);
    drive(1'b0, 1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, st);
    alu(4, 1, 2);

    // EX then MEM forwarding.
    alu(5, 1, 2);
    alu(6, 5, 1);
    alu(7, 5, 5);

    // Load-use: one stall, then MEM forward.
    lw(8, 3);
    alu(9, 8, 2);

    // WB-only dependency ahead of a branch.
    alu(10, 1, 2);
    alu(12, 1, 1);
    alu(13, 2, 2);
    branch(10, 0, 1'b0, 1'b1);

    // Branch / jump resolution.
    branch(1, 2, 1'b0, 1'b1);
    branch(1, 2, 1'b1, 1'b1);
    branch(1, 2, 1'b1, 1'b0);
    branch(1, 2, 1'b0, 1'b0);
    jal(1, 1'b0);
    jal(1, 1'b1);

    // x0 writes never create hazards.
    alu(0, 1, 2);
    lw(0, 1);
    alu(3, 0, 0);
    alu(3, 0, 0);

    // Stall-heavy stretch pushes the narrow counters into saturation.
    for (int k = 0; k < 12; k++) begin
      lw(20, 1);
      alu(21, 20, 20);
    end

    // Reset in the middle of a load-use stall discards the pending load.
    lw(8, 3);
    drive(1'b1, 1'b1, 8, 2, 9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, st);
    drive(1'b0, 1'b1, 8, 2, 9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, st);
    alu(9, 8, 2);

    // Random traffic over a small register set to make collisions frequent.
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom), st);
    end

    @(negedge clk);
    #1;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
